// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types, sizes and helpers for the multiply/divide unit
// Contents:
//   WIDTH_DEF   default operand width
//   CNT_W       width of the step counter
//   md_state_t  FSM state encoding (IDLE, MULT, DIV, FIX, FIN)
//   abs32       two's-complement magnitude of a 32-bit signed value
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } md_state_t;

  // Magnitude as an unsigned 32-bit value; -2^31 maps to 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// rtl/mult_div_unit_booth_step.sv - one combinational radix-2 Booth iteration
// Ports:
//   acc, q, q_1        current {acc, Q, q-1} register
//   m                  multiplicand
//   acc_next, q_next,
//   q_1_next           register after add/subtract and arithmetic shift right
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] acc_x;
  logic [WIDTH:0] m_x;
  logic [WIDTH:0] sum;

  assign acc_x = {acc[WIDTH-1], acc};
  assign m_x   = {m[WIDTH-1], m};

  // The add is done one bit wider so the shift pulls in the true sign.
  // With a WIDTH-bit sum, acc - (-2^(WIDTH-1)) would wrap and corrupt the
  // product when both operands are the most negative value.
  always_comb begin
    sum = acc_x;
    unique case ({q[0], q_1})
      2'b01:   sum = acc_x + m_x;
      2'b10:   sum = acc_x - m_x;
      default: sum = acc_x;
    endcase
  end

  assign acc_next = sum[WIDTH:1];
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide unit producing HI/LO
// Optional feature macro: MULTDIV_DIV_EN (divider, DIV/FIX states, Div_zero).
// Without it Start_div is ignored and Div_zero is constant 0.
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous active-low reset
//   Start_mult  one-cycle pulse: start signed A*B
//   Start_div   one-cycle pulse: start signed A/B
//   A, B        operands
//   Hi, Lo      product[63:32]/product[31:0] or remainder/quotient
//   Busy        operation in progress (MULT, DIV, FIX)
//   Done        one-cycle pulse, Hi/Lo valid
//   Div_zero    one-cycle pulse with Done when the divisor was 0
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start_mult,
  input  logic             Start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Div_zero
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Booth working register {acc, q, q_1} and the latched multiplicand
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q1_nx;

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc      (acc_q),
    .q        (q_q),
    .q_1      (q1_q),
    .m        (m_q),
    .acc_next (acc_nx),
    .q_next   (q_nx),
    .q_1_next (q1_nx)
  );

  logic last_step;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULTDIV_DIV_EN
  // Restoring divider on magnitudes: quo_q starts as |A| and fills with
  // quotient bits from the right as dividend bits shift out the left.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;

  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};
  assign div_fits  = ~div_trial[WIDTH];
`else
  logic div_unused;
  assign div_unused = Start_div;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      Hi       <= '0;
      Lo       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Div_zero <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`endif
    end else begin
      Done     <= 1'b0;
      Div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start_mult) begin
            acc_q <= '0;
            q_q   <= A;
            q1_q  <= 1'b0;
            m_q   <= B;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= MULT;
          end
`ifdef MULTDIV_DIV_EN
          else if (Start_div) begin
            if (B != '0) begin
              rem_q  <= '0;
              quo_q  <= abs32(A);
              dvs_q  <= abs32(B);
              sign_a <= A[WIDTH-1];
              sign_b <= B[WIDTH-1];
              cnt    <= '0;
              Busy   <= 1'b1;
              state  <= DIV;
            end else begin
              // Divide by zero completes at once and leaves Hi/Lo alone.
              Done     <= 1'b1;
              Div_zero <= 1'b1;
              state    <= FIN;
            end
          end
`endif
        end
        MULT: begin
          acc_q <= acc_nx;
          q_q   <= q_nx;
          q1_q  <= q1_nx;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            Hi    <= acc_nx;
            Lo    <= q_nx;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end
        end
`ifdef MULTDIV_DIV_EN
        DIV: begin
          rem_q <= div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], div_fits};
          cnt   <= cnt + CNT_W'(1);
          if (last_step) state <= FIX;
        end
        FIX: begin
          // Truncating division: quotient sign from the operand signs,
          // remainder sign follows the dividend.
          Lo    <= (sign_a ^ sign_b) ? (~quo_q + 1'b1) : quo_q;
          Hi    <= sign_a ? (~rem_q + 1'b1) : rem_q;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= FIN;
        end
`endif
        FIN: begin
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start_mult = 1'b0;
  logic        Start_div = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        Div_zero;

  mult_div_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start_mult (Start_mult),
    .Start_div  (Start_div),
    .A          (A),
    .B          (B),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .Done       (Done),
    .Div_zero   (Div_zero)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    ref_hi = p[63:32];
    ref_lo = p[31:0];
  endtask

  task automatic model_div(input logic [31:0] a, input logic [31:0] b, output bit dz);
    longint q;
    longint r;
    dz = (b == 32'd0);
    if (!dz) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      ref_lo = q[31:0];
      ref_hi = r[31:0];
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h0000_0000;
      3:       v = 32'h0000_0001;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one operation from IDLE, waits for Done, checks, then spends one
  // more edge so the next call starts in IDLE right after FIN.
  task automatic do_op(input bit do_mult, input bit do_div, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    int n;
    int exp_lat;
    int seen;
    bit dz;
    bit run;
    A = a;
    B = b;
    Start_mult = do_mult;
    Start_div  = do_div;
    dz = 1'b0;
    run = 1'b1;
    exp_lat = 33;
    if (do_mult) begin
      model_mult(a, b);
    end else begin
`ifdef MULTDIV_DIV_EN
      model_div(a, b, dz);
      exp_lat = dz ? 1 : 34;
`else
      run = 1'b0;
`endif
    end
    @(posedge Clk); #1;
    Start_mult = 1'b0;
    Start_div  = 1'b0;
    n = 1;
    if (run) begin
      check({tag, "_busy"}, 64'(Busy), 64'(exp_lat > 1));
      while (!Done && n < 40) begin
        @(posedge Clk); #1;
        n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_hi"}, 64'(Hi), 64'(ref_hi));
      check({tag, "_lo"}, 64'(Lo), 64'(ref_lo));
      check({tag, "_dz"}, 64'(Div_zero), 64'(dz));
    end else begin
      seen = 0;
      repeat (40) begin
        if (Busy || Done || Div_zero) seen++;
        @(posedge Clk); #1;
      end
      check({tag, "_ignored"}, 64'(seen), 64'd0);
      check({tag, "_hold"}, {Hi, Lo}, {ref_hi, ref_lo});
    end
    @(posedge Clk); #1;
    check({tag, "_idle"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;

    // 1. reset held for two edges
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_hilo", {Hi, Lo}, 64'd0);
    check("rst_flags", {61'd0, Busy, Done, Div_zero}, 64'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // 2-3. directed multiplies
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "t2");
    check("t2_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "t3");
    check("t3_const", {Hi, Lo}, 64'h4000_0000_0000_0000);

    // 4-5. directed divides (ignored when the divider is not built)
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "t4");
    do_op(1'b0, 1'b1, 32'd123, 32'd0, "t5");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf");

    // randomized operations, each started the cycle after the previous FIN
    for (int i = 0; i < 16; i++) begin
      ra = pick();
      rb = pick();
      do_op(1'b1, 1'b0, ra, rb, $sformatf("rmul%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : pick();
      do_op(1'b0, 1'b1, ra, rb, $sformatf("rdiv%0d", i));
    end

    // 6a. Start_div pulsed during a multiply is ignored
    ra = $urandom;
    rb = $urandom;
    model_mult(ra, rb);
    A = ra;
    B = rb;
    Start_mult = 1'b1;
    @(posedge Clk); #1;
    Start_mult = 1'b0;
    n = 1;
    while (!Done && n < 40) begin
      if (n == 5) begin
        A = 32'd9;
        B = 32'd3;
        Start_div = 1'b1;
      end else begin
        Start_div = 1'b0;
      end
      @(posedge Clk); #1;
      n++;
    end
    Start_div = 1'b0;
    check("t6_lat", 64'(n), 64'd33);
    check("t6_res", {Hi, Lo}, {ref_hi, ref_lo});
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Busy || Done) seen++;
    end
    check("t6_noqueue", 64'(seen), 64'd0);

    // 6b. reset at step 10 of a multiply aborts it
    A = 32'h1234_5678;
    B = 32'h0000_0011;
    Start_mult = 1'b1;
    @(posedge Clk); #1;
    Start_mult = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("t6_abort_busy", 64'(Busy), 64'd0);
    check("t6_abort_hilo", {Hi, Lo}, 64'd0);
    check("t6_abort_done", 64'(Done), 64'd0);
    Reset = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Busy || Done) seen++;
    end
    check("t6_no_done", 64'(seen), 64'd0);

    // 6c. simultaneous starts run the multiply
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, "both");
    check("both_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
